// File: rtl/dbus_router_if.sv
// Host-side and slave-side signal bundle around dbus_router; the router uses the
// slave modport, the LSU/slave environment uses the master modport.
interface dbus_router_if #(
    parameter int NumSlaves = 3
);
    logic                    h_req_i;
    logic                    h_we_i;
    logic [3:0]              h_be_i;
    logic [31:0]             h_addr_i;
    logic [31:0]             h_wdata_i;
    logic                    h_gnt_o;
    logic                    h_rvalid_o;
    logic [31:0]             h_rdata_o;
    logic                    h_err_o;
    logic [NumSlaves-1:0]    s_req_o;
    logic                    s_we_o;
    logic [3:0]              s_be_o;
    logic [31:0]             s_addr_o;
    logic [31:0]             s_wdata_o;
    logic [NumSlaves-1:0]    s_gnt_i;
    logic [NumSlaves-1:0]    s_rvalid_i;
    logic [NumSlaves*32-1:0] s_rdata_i;

    modport slave (
        input  h_req_i, h_we_i, h_be_i, h_addr_i, h_wdata_i,
        output h_gnt_o, h_rvalid_o, h_rdata_o, h_err_o,
        output s_req_o, s_we_o, s_be_o, s_addr_o, s_wdata_o,
        input  s_gnt_i, s_rvalid_i, s_rdata_i
    );

    modport master (
        output h_req_i, h_we_i, h_be_i, h_addr_i, h_wdata_i,
        input  h_gnt_o, h_rvalid_o, h_rdata_o, h_err_o,
        input  s_req_o, s_we_o, s_be_o, s_addr_o, s_wdata_o,
        output s_gnt_i, s_rvalid_i, s_rdata_i
    );
endinterface

// File: rtl/dbus_router.sv
// Data-side interconnect: base/mask decode to NumSlaves targets plus an internal error target,
// in-order response FIFO. Optional protocol checker enabled by DBUS_ROUTER_PROT_CHECK_EN.
module dbus_router #(
    parameter int                      NumSlaves      = 3,
    parameter int                      MaxOutstanding = 2,
    parameter logic [NumSlaves*32-1:0] SlaveBase      = {32'h0010_0000, 32'h0000_0000, 32'h2000_0000},
    parameter logic [NumSlaves*32-1:0] SlaveMask      = {32'h000F_FFFF, 32'h000F_FFFF, 32'h0FFF_FFFF}
) (
    input  logic         clk,
    input  logic         rst_n,
    dbus_router_if.slave bus,
    output logic         prot_err_o
);
    localparam int SelW = $clog2(NumSlaves + 1);
    localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CntW = $clog2(MaxOutstanding + 1);
    localparam logic [SelW-1:0] ErrSel = SelW'(NumSlaves);

    logic [NumSlaves-1:0] hit;
    logic [31:0]          slave_rdata [NumSlaves];
    logic [SelW-1:0]      sel;
    logic [31:0]          sel_mask;
    logic                 sel_gnt;

    logic [SelW-1:0]      fifo_q [MaxOutstanding];
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]      count_q, count_d;
    logic [SelW-1:0]      head;
    logic                 empty;
    logic                 full;
    logic                 push;
    logic                 pop;

    logic                 rsp_valid;
    logic [31:0]          rsp_data;
    logic                 rsp_err;

    for (genvar gi = 0; gi < NumSlaves; gi++) begin : g_slave
        assign hit[gi]         = (bus.h_addr_i & ~SlaveMask[gi*32 +: 32]) == SlaveBase[gi*32 +: 32];
        assign slave_rdata[gi] = bus.s_rdata_i[gi*32 +: 32];
    end

    // Scan from the top so the lowest-index hit is the one left standing.
    always_comb begin
        sel      = ErrSel;
        sel_mask = '0;
        sel_gnt  = 1'b1;
        for (int k = NumSlaves - 1; k >= 0; k--) begin
            if (hit[k]) begin
                sel      = SelW'(k);
                sel_mask = SlaveMask[k*32 +: 32];
                sel_gnt  = bus.s_gnt_i[k];
            end
        end
    end

    assign empty = (count_q == '0);
    assign full  = (count_q == CntW'(MaxOutstanding));

    for (genvar gi = 0; gi < NumSlaves; gi++) begin : g_req
        assign bus.s_req_o[gi] = rst_n & bus.h_req_i & ~full & (sel == SelW'(gi));
    end

    assign bus.s_we_o    = bus.h_we_i;
    assign bus.s_be_o    = bus.h_be_i;
    assign bus.s_wdata_o = bus.h_wdata_i;
    assign bus.s_addr_o  = bus.h_addr_i & sel_mask;
    assign bus.h_gnt_o   = rst_n & ~full & sel_gnt;

    assign push = bus.h_req_i & bus.h_gnt_o;
    assign head = fifo_q[rd_ptr_q];

    // Only the head entry may answer; the error target answers as soon as it reaches the head.
    always_comb begin
        rsp_valid = 1'b0;
        rsp_data  = '0;
        rsp_err   = 1'b0;
        if (!empty) begin
            if (head == ErrSel) begin
                rsp_valid = 1'b1;
                rsp_err   = 1'b1;
            end else begin
                for (int k = 0; k < NumSlaves; k++) begin
                    if (head == SelW'(k)) begin
                        rsp_valid = bus.s_rvalid_i[k];
                        rsp_data  = slave_rdata[k];
                    end
                end
            end
        end
    end

    assign bus.h_rvalid_o = rst_n & rsp_valid;
    assign bus.h_rdata_o  = rsp_data;
    assign bus.h_err_o    = rst_n & rsp_err;
    assign pop            = bus.h_rvalid_o;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(MaxOutstanding - 1)) begin
            return '0;
        end
        return p + PtrW'(1);
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset: the count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= sel;
        end
    end

`ifdef DBUS_ROUTER_PROT_CHECK_EN
    logic                 prot_err_q;
    logic                 prot_err_d;
    logic [NumSlaves-1:0] head_onehot;
    logic                 multi_rvalid;

    for (genvar gi = 0; gi < NumSlaves; gi++) begin : g_head
        assign head_onehot[gi] = ~empty & (head == SelW'(gi));
    end

    assign multi_rvalid = (bus.s_rvalid_i & (bus.s_rvalid_i - NumSlaves'(1))) != '0;
    assign prot_err_d   = prot_err_q
                        | (|(bus.s_rvalid_i & ~head_onehot))
                        | (|(bus.s_gnt_i & ~bus.s_req_o))
                        | multi_rvalid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prot_err_q <= 1'b0;
        end else begin
            prot_err_q <= prot_err_d;
        end
    end

    assign prot_err_o = prot_err_q;
`else
    assign prot_err_o = 1'b0;
`endif

endmodule
